// File: rtl/sha_core_arbiter.sv
// sha_core_arbiter: round-robin scheduler sharing one SHA-256 compression core among NREQ requesters.
// Define SHA_ARB_TIMEOUT_EN to build the WAIT-state watchdog (limit TIMEOUT_CYCLES); otherwise err is tied low.
module sha_core_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*512-1:0] req_block,
  input  logic [NREQ-1:0]     req_init,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     ack,
  output logic [255:0]        digest,
  output logic                err,
  output logic                busy,
  output logic [15:0]         jobs_done,
  output logic                core_start,
  output logic [511:0]        core_block,
  output logic                core_init,
  input  logic                core_done,
  input  logic [255:0]        core_digest
);
  // state  | meaning
  // IDLE   | arbitrate among req, latch the winner's block and init flag
  // LAUNCH | one-cycle core_start pulse, gnt raised, ptr moves to winner
  // WAIT   | hold gnt until core_done (or watchdog expiry)
  // RESP   | one-cycle ack with digest, gnt released on exit

  localparam int IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : gBadParam
    $error("sha_core_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} stateT;

  stateT           state;
  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] pick;
  logic            anyReq;
  logic [511:0]    blkArr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : gSlice
    assign blkArr[g] = req_block[512*g +: 512];
  end

  // Offsets are scanned from farthest to nearest so the nearest set bit after ptr wins;
  // ptr itself (offset NREQ) is the lowest priority.
  always_comb begin : pArb
    int idx;
    idx    = 0;
    pick   = ptr;
    anyReq = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NREQ;
      if (req[IdxW'(idx)]) begin
        pick   = IdxW'(idx);
        anyReq = 1'b1;
      end
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdCnt;
  logic           errQ;
  assign err = errQ;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      ack        <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      digest     <= '0;
      jobs_done  <= '0;
      core_block <= '0;
      core_init  <= 1'b0;
      ptr        <= IdxW'(NREQ - 1);
      winner     <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
      wdCnt      <= '0;
      errQ       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            winner     <= pick;
            core_block <= blkArr[pick];
            core_init  <= req_init[pick];
            gnt        <= NREQ'(1) << pick;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          core_start <= 1'b0;
          ptr        <= winner;
`ifdef SHA_ARB_TIMEOUT_EN
          wdCnt      <= WdW'(TIMEOUT_CYCLES);
`endif
          state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            digest    <= core_digest;
            ack       <= gnt;
            jobs_done <= jobs_done + 16'd1;
`ifdef SHA_ARB_TIMEOUT_EN
            errQ      <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef SHA_ARB_TIMEOUT_EN
          // Down-counter reaching zero means TIMEOUT_CYCLES WAIT cycles passed without core_done.
          else if (wdCnt == '0) begin
            digest    <= '0;
            ack       <= gnt;
            jobs_done <= jobs_done + 16'd1;
            errQ      <= 1'b1;
            state     <= RESP;
          end else begin
            wdCnt <= wdCnt - 1'b1;
          end
`endif
        end
        RESP: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha_core_arbiter.md
# sha_core_arbiter

Round-robin scheduler that shares one SHA-256 compression core among NREQ requesters (miner lanes or message-split front ends). It accepts a 512-bit block plus an init/chain flag from each requester and launches one job at a time on the core. When the job finishes, it returns the 256-bit digest to the owning requester with a one-cycle acknowledge. It sits between the per-lane message schedulers and the single shared compression datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal 2..8
- TIMEOUT_CYCLES, 1023, WAIT-state watchdog limit; used only when the watchdog is compiled in

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester job request, level
- req_block  in  NREQ*512  per-requester message block; slice i = bits [512*i+511 : 512*i]
- req_init  in  NREQ  1 = core starts from the SHA-256 IV; 0 = core chains from its previous state
- gnt  out  NREQ  one-hot owner of the core
- ack  out  NREQ  one-cycle pulse to the owner; digest is valid in the same cycle
- digest  out  256  registered result; holds its value until the next ack
- err  out  1  qualifies ack; 1 = job aborted by the watchdog
- busy  out  1  high in every state except IDLE
- jobs_done  out  16  count of completed acks; wraps from 0xFFFF to 0
- core_start  out  1  one-cycle launch pulse to the core
- core_block  out  512  latched block for the core
- core_init  out  1  latched init flag for the core
- core_done  in  1  completion pulse from the core
- core_digest  in  256  core result; sampled only when core_done is high

## Operation
- State machine: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE
  - If any req bit is high, select the first set bit searching upward from ptr+1, with modulo-NREQ wrap.
  - Latch that requester's req_block and req_init into core_block and core_init.
  - Store the winner's index and go to LAUNCH.
- LAUNCH (one cycle): gnt[winner]=1, core_start=1, ptr<=winner, then go to WAIT.
- WAIT
  - Hold gnt.
  - On core_done=1: latch core_digest into digest, set err<=0, go to RESP.
- RESP (one cycle)
  - ack[winner]=1 and gnt still high.
  - jobs_done increments by 1, modulo 2^16.
  - Then go to IDLE and clear gnt.
- Round-robin fairness: the requester just served has lowest priority at the next arbitration.
- Request stability:
  - req and req_block need only be valid in the IDLE cycle that selects them.
  - Dropping req after selection does not cancel the job; ack is still issued.
- core_done outside WAIT is ignored, including a core_done in the same cycle as core_start.
- Reset at any point:
  - state=IDLE; gnt, ack, core_start, busy, err = 0.
  - digest = 0, jobs_done = 0, core_block = 0, core_init = 0.
  - ptr = NREQ-1, so requester 0 wins first.
  - A job in flight is abandoned. Its later core_done is ignored.

## Timing
- req seen in IDLE at cycle T -> gnt and core_start high at T+1.
- core_done at cycle D -> ack and digest valid at D+1.
- gnt is high from T+1 through D+1 inclusive.
- The earliest next arbitration is D+2. Back-to-back jobs therefore cost core latency + 3 cycles of overhead.
- All outputs are registered; there are no combinational paths from req to gnt, or from core_done to ack.

## Configuration
- SHA_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES with no core_done, go to RESP with err=1 and digest=0.
  - ack and jobs_done behave normally.
- SHA_ARB_TIMEOUT_EN not defined:
  - No counter is built and err is tied to 0.
  - WAIT holds indefinitely until core_done.

## Test plan
- Reset, then req=4'b0001 with block=0x61626380 followed by zeros and length word 0x18, init=1; core model returns ba7816bf...f20015ad after 64 cycles -> gnt=0001 at T+1, ack[0] and that digest at D+1, jobs_done=1.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; exactly one gnt bit high at a time; ack spacing equals core latency + 3.
- ptr=1 after serving requester 1, then req=4'b0011 -> next grant goes to requester 0 (wrap), not requester 1.
- Spurious core_done during IDLE and during LAUNCH -> no ack, digest unchanged, state unaffected.
- rst pulsed for one cycle mid-WAIT, then core_done arrives -> all outputs 0, no ack, and the next req=0100 is granted normally.
- With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=15, core never responds -> ack with err=1 and digest=0 at 17 cycles after LAUNCH; without the macro, busy stays high indefinitely.
